// File: rtl/svf_mc.sv
// Time-multiplexed Chamberlin state-variable filter for N_CH channels sharing one multiplier.
// Each accepted sample walks IDLE -> QB -> FH -> FB -> OUT; state is written back on leaving FB.
module svf_mc #(
   parameter  int N_CH      = 4,
   parameter  int DATA_W    = 16,
   parameter  int COEF_W    = 16,
   parameter  int COEF_FRAC = 14,
   localparam int CH_W      = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CH_W-1:0]          in_ch,
   input  logic signed [DATA_W-1:0] in_x,
   input  logic                     coef_we,
   input  logic [CH_W-1:0]          coef_ch,
   input  logic signed [COEF_W-1:0] coef_f,
   input  logic signed [COEF_W-1:0] coef_q,
   input  logic [1:0]               coef_mode,
   input  logic                     clr_we,
   input  logic [CH_W-1:0]          clr_ch,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          out_ch,
   output logic signed [DATA_W-1:0] out_yh,
   output logic signed [DATA_W-1:0] out_yb,
   output logic signed [DATA_W-1:0] out_yl,
   output logic signed [DATA_W-1:0] out_yn,
   output logic signed [DATA_W-1:0] out_y
);

   localparam int PW = DATA_W + COEF_W;
   localparam logic signed [PW-1:0] MAX_W = (PW'(1) <<< (DATA_W - 1)) - PW'(1);
   localparam logic signed [PW-1:0] MIN_W = ~MAX_W;

   typedef enum logic [2:0] {S_IDLE, S_QB, S_FH, S_FB, S_OUT} state_t;

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
      logic signed [DATA_W-1:0] r;
      if (v > MAX_W) begin
         r = MAX_W[DATA_W-1:0];
      end else if (v < MIN_W) begin
         r = MIN_W[DATA_W-1:0];
      end else begin
         r = v[DATA_W-1:0];
      end
      return r;
   endfunction

   function automatic logic signed [PW-1:0] sext(input logic signed [DATA_W-1:0] a);
      return {{(PW-DATA_W){a[DATA_W-1]}}, a};
   endfunction

   function automatic logic signed [DATA_W-1:0] add_sat(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
      return sat(sext(a) + sext(b));
   endfunction

   function automatic logic signed [DATA_W-1:0] sub_sat(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
      return sat(sext(a) - sext(b));
   endfunction

   function automatic logic signed [DATA_W-1:0] mul_sat(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [COEF_W-1:0] c);
      logic signed [PW-1:0] p;
      p = a * c;
      return sat(p >>> COEF_FRAC);
   endfunction

   state_t state_q, state_d;
   logic [CH_W-1:0]          ch_q;
   logic signed [DATA_W-1:0] x_q, yb_q, yl_q, yh_q;
   logic signed [COEF_W-1:0] f_q, qc_q;
   logic [1:0]               mode_q;
   logic                     kill_q;
   logic                     out_valid_q;
   logic [CH_W-1:0]          out_ch_q;
   logic signed [DATA_W-1:0] out_yh_q, out_yb_q, out_yl_q, out_yn_q, out_y_q;

   logic signed [COEF_W-1:0] f_rf_q    [N_CH];
   logic signed [COEF_W-1:0] q_rf_q    [N_CH];
   logic [1:0]               mode_rf_q [N_CH];
   logic signed [DATA_W-1:0] yb_rf_q   [N_CH];
   logic signed [DATA_W-1:0] yl_rf_q   [N_CH];

   logic signed [DATA_W-1:0] mul_a_s, mul_r_s;
   logic signed [COEF_W-1:0] mul_c_s;
   logic signed [DATA_W-1:0] yh_new_s, yb_new_s, yl_new_s, yn_new_s, y_sel_s;
   logic                     accept_s, clr_hit_s;

   assign in_ready  = (state_q == S_IDLE);
   assign accept_s  = (state_q == S_IDLE) && in_valid;
   assign clr_hit_s = clr_we && (clr_ch == ch_q);

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_yh    = out_yh_q;
   assign out_yb    = out_yb_q;
   assign out_yl    = out_yl_q;
   assign out_yn    = out_yn_q;
   assign out_y     = out_y_q;

   // Shared multiplier operand select: yb*Q, then yh*F, then yb'*F.
   always_comb begin
      mul_a_s = '0;
      mul_c_s = '0;
      case (state_q)
         S_QB:    begin mul_a_s = yb_q; mul_c_s = qc_q; end
         S_FH:    begin mul_a_s = yh_q; mul_c_s = f_q;  end
         S_FB:    begin mul_a_s = yb_q; mul_c_s = f_q;  end
         default: begin mul_a_s = '0;   mul_c_s = '0;   end
      endcase
      mul_r_s  = mul_sat(mul_a_s, mul_c_s);
      yh_new_s = sub_sat(sub_sat(x_q, yl_q), mul_r_s);
      yb_new_s = add_sat(yb_q, mul_r_s);
      yl_new_s = add_sat(yl_q, mul_r_s);
      yn_new_s = add_sat(yh_q, yl_new_s);
      case (mode_q)
         2'd0:    y_sel_s = yl_new_s;
         2'd1:    y_sel_s = yb_q;
         2'd2:    y_sel_s = yh_q;
         2'd3:    y_sel_s = yn_new_s;
         default: y_sel_s = '0;
      endcase
   end

   // Next-state sequencing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_QB; else state_d = S_IDLE;
         S_QB:    state_d = S_FH;
         S_FH:    state_d = S_FB;
         S_FB:    state_d = S_OUT;
         S_OUT:   if (out_ready) state_d = S_IDLE; else state_d = S_OUT;
         default: state_d = S_IDLE;
      endcase
   end

   // Working registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         x_q         <= '0;
         f_q         <= '0;
         qc_q        <= '0;
         mode_q      <= 2'd0;
         yb_q        <= '0;
         yl_q        <= '0;
         yh_q        <= '0;
         kill_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_yh_q    <= '0;
         out_yb_q    <= '0;
         out_yl_q    <= '0;
         out_yn_q    <= '0;
         out_y_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept_s) begin
            ch_q   <= in_ch;
            x_q    <= in_x;
            f_q    <= f_rf_q[in_ch];
            qc_q   <= q_rf_q[in_ch];
            mode_q <= mode_rf_q[in_ch];
            yb_q   <= yb_rf_q[in_ch];
            yl_q   <= yl_rf_q[in_ch];
            kill_q <= clr_we && (clr_ch == in_ch);
         end else if (state_q != S_IDLE && state_q != S_OUT) begin
            kill_q <= kill_q | clr_hit_s;
         end
         if (state_q == S_QB) yh_q <= yh_new_s;
         if (state_q == S_FH) yb_q <= yb_new_s;
         // Leaving FB: publish the result; yb_q already holds yb'.
         if (state_q == S_FB) begin
            yl_q        <= yl_new_s;
            out_valid_q <= 1'b1;
            out_ch_q    <= ch_q;
            out_yh_q    <= yh_q;
            out_yb_q    <= yb_q;
            out_yl_q    <= yl_new_s;
            out_yn_q    <= yn_new_s;
            out_y_q     <= y_sel_s;
         end else if (state_q == S_OUT && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Per-channel coefficient and state files; a clear beats the FB writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            f_rf_q[i]    <= '0;
            q_rf_q[i]    <= '0;
            mode_rf_q[i] <= 2'd0;
            yb_rf_q[i]   <= '0;
            yl_rf_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (coef_we && coef_ch == CH_W'(i)) begin
               f_rf_q[i]    <= coef_f;
               q_rf_q[i]    <= coef_q;
               mode_rf_q[i] <= coef_mode;
            end
            if (clr_we && clr_ch == CH_W'(i)) begin
               yb_rf_q[i] <= '0;
               yl_rf_q[i] <= '0;
            end else if (state_q == S_FB && ch_q == CH_W'(i) && !kill_q) begin
               yb_rf_q[i] <= yb_q;
               yl_rf_q[i] <= yl_new_s;
            end
         end
      end
   end

endmodule

// File: tb/tb_svf_mc.sv
// Randomised self-checking bench for svf_mc against an integer reference of the filter equations.
module tb_svf_mc;
   localparam int N_CH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [1:0]  in_ch;
   logic [15:0] in_x;
   logic        coef_we;
   logic [1:0]  coef_ch;
   logic [15:0] coef_f, coef_q;
   logic [1:0]  coef_mode;
   logic        clr_we;
   logic [1:0]  clr_ch;
   logic        out_valid, out_ready;
   logic [1:0]  out_ch;
   logic [15:0] out_yh, out_yb, out_yl, out_yn, out_y;

   svf_mc dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_x(in_x),
      .coef_we(coef_we), .coef_ch(coef_ch), .coef_f(coef_f), .coef_q(coef_q), .coef_mode(coef_mode),
      .clr_we(clr_we), .clr_ch(clr_ch),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
      .out_yh(out_yh), .out_yb(out_yb), .out_yl(out_yl), .out_yn(out_yn), .out_y(out_y)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int m_f[N_CH], m_q[N_CH], m_mode[N_CH], m_yb[N_CH], m_yl[N_CH];
   int e_yh, e_yb, e_yl, e_yn, e_y;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic int mul(input int a, input int c);
      longint p;
      p = longint'(a) * longint'(c);
      return sat(p >>> 14);
   endfunction

   task automatic model_run(input int ch, input int x);
      e_yh = sat(longint'(sat(longint'(x) - m_yl[ch])) - mul(m_yb[ch], m_q[ch]));
      e_yb = sat(longint'(m_yb[ch]) + mul(e_yh, m_f[ch]));
      e_yl = sat(longint'(m_yl[ch]) + mul(e_yb, m_f[ch]));
      e_yn = sat(longint'(e_yh) + e_yl);
      case (m_mode[ch])
         0: e_y = e_yl;
         1: e_y = e_yb;
         2: e_y = e_yh;
         default: e_y = e_yn;
      endcase
      m_yb[ch] = e_yb;
      m_yl[ch] = e_yl;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_f[i] = 0; m_q[i] = 0; m_mode[i] = 0; m_yb[i] = 0; m_yl[i] = 0;
      end
   endtask

   task automatic set_coef(input int ch, input int f, input int q, input int mode);
      @(negedge clk);
      coef_we = 1'b1; coef_ch = 2'(ch); coef_f = 16'(f); coef_q = 16'(q); coef_mode = 2'(mode);
      @(posedge clk);
      m_f[ch] = f; m_q[ch] = q; m_mode[ch] = mode;
      #1 coef_we = 1'b0;
   endtask

   task automatic clr_idle(input int ch);
      @(negedge clk);
      clr_we = 1'b1; clr_ch = 2'(ch);
      @(posedge clk);
      m_yb[ch] = 0; m_yl[ch] = 0;
      #1 clr_we = 1'b0;
   endtask

   // extra: 0 none, 1 clear the in-flight channel, 2 rewrite its F while busy
   task automatic do_sample(input int ch, input int x, input int hold, input int extra);
      int n;
      int lat;
      int nf;
      @(negedge clk);
      out_ready = (hold == 0);
      in_valid = 1'b1; in_ch = 2'(ch); in_x = 16'(x);
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 0, 1);
         in_valid = 1'b0;
         out_ready = 1'b1;
         return;
      end
      @(posedge clk);
      model_run(ch, x);
      #1;
      in_valid = 1'b0;
      if (extra == 1) begin
         clr_we = 1'b1; clr_ch = 2'(ch);
         m_yb[ch] = 0; m_yl[ch] = 0;
      end else if (extra == 2) begin
         nf = int'($urandom_range(0, 65535)) - 32768;
         coef_we = 1'b1; coef_ch = 2'(ch); coef_f = 16'(nf);
         coef_q = 16'(m_q[ch]); coef_mode = 2'(m_mode[ch]);
         m_f[ch] = nf;
      end
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
         clr_we = 1'b0;
         coef_we = 1'b0;
      end
      chk("latency", lat, 3);
      chk("out_ch", int'(out_ch), ch);
      chk("yh", int'($signed(out_yh)), e_yh);
      chk("yb", int'($signed(out_yb)), e_yb);
      chk("yl", int'($signed(out_yl)), e_yl);
      chk("yn", int'($signed(out_yn)), e_yn);
      chk("y",  int'($signed(out_y)),  e_y);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; in_ch = 2'((ch + 1) % N_CH); in_x = 16'd12345;
         @(posedge clk);
         #1;
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_y", int'($signed(out_y)), e_y);
         chk("stall_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("valid_drop", int'(out_valid), 0);
   endtask

   initial begin
      int op, ch, x;
      rst = 1'b1; in_valid = 1'b0; in_ch = 2'd0; in_x = 16'd0;
      coef_we = 1'b0; coef_ch = 2'd0; coef_f = 16'd0; coef_q = 16'd0; coef_mode = 2'd0;
      clr_we = 1'b0; clr_ch = 2'd0; out_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_y", int'(out_y), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_ready", int'(in_ready), 1);

      set_coef(0, 0, 0, 2);
      do_sample(0, 1000, 0, 0);
      chk("t1_y", int'($signed(out_y)), 1000);
      chk("t1_yn", int'($signed(out_yn)), 1000);

      set_coef(1, 16'h2000, 0, 0);
      do_sample(1, 1000, 0, 0);
      chk("t2a_y", int'($signed(out_y)), 250);
      chk("t2a_yb", int'($signed(out_yb)), 500);
      do_sample(1, 1000, 0, 0);
      chk("t2b_y", int'($signed(out_y)), 687);
      chk("t2b_yb", int'($signed(out_yb)), 875);
      chk("t2b_yh", int'($signed(out_yh)), 750);

      set_coef(2, 16'h4000, 0, 1);
      do_sample(2, 32767, 0, 0);
      chk("t3a_yl", int'($signed(out_yl)), 32767);
      do_sample(2, 32767, 0, 0);
      chk("t3b_yh", int'($signed(out_yh)), 0);
      chk("t3b_yb", int'($signed(out_yb)), 32767);
      do_sample(2, -32768, 0, 0);

      for (int i = 0; i < 6; i++)
         do_sample(i % 2, int'($urandom_range(0, 8000)) - 4000, 0, 0);

      do_sample(1, 300, 10, 0);
      do_sample(2, 100, 0, 0);

      do_sample(0, 2000, 0, 1);
      do_sample(0, 1500, 0, 0);
      do_sample(1, 400, 0, 2);
      do_sample(1, 400, 0, 0);

      // Reset while a ch1 sample sits in FH.
      @(negedge clk);
      in_valid = 1'b1; in_ch = 2'd1; in_x = 16'd500;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_yh", int'(out_yh), 0);
      chk("mid_rst_ch", int'(out_ch), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      set_coef(1, 16'h2000, 0, 0);
      do_sample(1, 1000, 0, 0);
      chk("post_rst_y", int'($signed(out_y)), 250);

      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 9));
         ch = int'($urandom_range(0, N_CH - 1));
         if (op < 2) begin
            set_coef(ch, int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)));
         end else if (op == 2) begin
            clr_idle(ch);
         end else begin
            x = int'($urandom_range(0, 65535)) - 32768;
            do_sample(ch, x, (op == 9) ? 2 : 0, (op == 8) ? int'($urandom_range(1, 2)) : 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
